// File: rtl/dmem_bus_responder_if.sv
// CPU data-port bus between the memory stage and the data responder.
interface dmem_bus_responder_if;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        mem_rw;
    logic [31:0] rdata_out;

    modport master (output addr_in, output wdata_in, output mem_rw, input rdata_out);
    modport slave  (input addr_in, input wdata_in, input mem_rw, output rdata_out);
endinterface

// File: rtl/dmem_bus_responder.sv
// Data-side responder: word RAM plus MMIO registers (LED, cycle counter, timer).
// Optional store counter at MMIO offset 0x10 is enabled by DMEM_STORE_STATS_EN.
module dmem_bus_responder #(
    parameter int          RAM_ADDR_W = 10,
    parameter logic [31:0] MMIO_BASE  = 32'hF000_0000,
    parameter int          LED_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_bus_responder_if.slave  bus,
    output logic [LED_W-1:0]     led_out,
    output logic                 irq_out
);
    localparam logic [5:0] OFF_LED    = 6'h00;
    localparam logic [5:0] OFF_CYCLE  = 6'h01;
    localparam logic [5:0] OFF_CMP    = 6'h02;
    localparam logic [5:0] OFF_STATUS = 6'h03;
    localparam logic [5:0] OFF_STORES = 6'h04;

    logic [31:0] ram [2**RAM_ADDR_W];
    logic [31:0] cycle;
    logic [31:0] cmp;
    logic        flag;
    logic [31:0] rdata;

    logic                  sel_ram;
    logic                  sel_mmio;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic [5:0]            woff;
    logic                  mmio_wr;

    // Byte lane bits and the middle of the MMIO window are don't-care address bits.
    logic unused_addr;
    assign unused_addr = ^{bus.addr_in[27:8], bus.addr_in[1:0]};

    assign sel_ram  = (bus.addr_in[31:28] == 4'h0);
    assign sel_mmio = (bus.addr_in[31:28] == MMIO_BASE[31:28]);
    assign ram_idx  = bus.addr_in[RAM_ADDR_W+1:2];
    assign woff     = bus.addr_in[7:2];
    assign mmio_wr  = bus.mem_rw && sel_mmio;

    // RAM contents survive reset; a store during reset still lands.
    always_ff @(posedge clk) begin
        if (bus.mem_rw && sel_ram)
            ram[ram_idx] <= bus.wdata_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_out <= '0;
            cycle   <= '0;
            cmp     <= '0;
            flag    <= 1'b0;
        end else begin
            if (mmio_wr && woff == OFF_LED)
                led_out <= bus.wdata_in[LED_W-1:0];
            cycle <= (mmio_wr && woff == OFF_CYCLE) ? 32'h0 : cycle + 32'h1;
            if (mmio_wr && woff == OFF_CMP)
                cmp <= bus.wdata_in;
            // Match is checked against the pre-increment count; a match beats W1C.
            if (cycle == cmp && cmp != 32'h0)
                flag <= 1'b1;
            else if (mmio_wr && woff == OFF_STATUS && bus.wdata_in[0])
                flag <= 1'b0;
        end
    end

    assign irq_out = flag;

`ifdef DMEM_STORE_STATS_EN
    logic [31:0] stores;

    // Counts every store, mapped or not; clearing via 0x10 beats the increment.
    always_ff @(posedge clk) begin
        if (rst)
            stores <= '0;
        else if (mmio_wr && woff == OFF_STORES)
            stores <= '0;
        else if (bus.mem_rw)
            stores <= stores + 32'h1;
    end
`endif

    always_comb begin
        rdata = '0;
        if (sel_ram) begin
            rdata = ram[ram_idx];
        end else if (sel_mmio) begin
            case (woff)
                OFF_LED:    rdata[LED_W-1:0] = led_out;
                OFF_CYCLE:  rdata = cycle;
                OFF_CMP:    rdata = cmp;
                OFF_STATUS: rdata[0] = flag;
`ifdef DMEM_STORE_STATS_EN
                OFF_STORES: rdata = stores;
`endif
                default:    rdata = '0;
            endcase
        end
    end

    assign bus.rdata_out = rdata;
endmodule

// File: tb/tb_dmem_bus_responder.sv
// Directed self-checking bench for dmem_bus_responder (both DMEM_STORE_STATS_EN builds).
module tb_dmem_bus_responder;
    logic        clk;
    logic        rst;
    logic [15:0] led;
    logic        irq;
    int          checks;
    int          errors;

    dmem_bus_responder_if bus ();

    dmem_bus_responder #(
        .RAM_ADDR_W (10),
        .MMIO_BASE  (32'hF000_0000),
        .LED_W      (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .led_out (led),
        .irq_out (irq)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr_in  = a;
        bus.wdata_in = d;
        bus.mem_rw   = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_rw   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.addr_in = a;
        bus.mem_rw  = 1'b0;
        #1;
        chk(tag, bus.rdata_out, exp);
    endtask

    initial begin
        logic [31:0] stores_exp;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.addr_in  = '0;
        bus.wdata_in = '0;
        bus.mem_rw   = 1'b0;
        step(2);

        chk("rst_led", {16'h0, led}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        rd_chk("rst_cycle", 32'hF000_0004, 32'h0);
        rd_chk("rst_cmp", 32'hF000_0008, 32'h0);
        rd_chk("rst_stores", 32'hF000_0010, 32'h0);

        // Cycle counter
        rst = 1'b0;
        step(10);
        rd_chk("cycle_10", 32'hF000_0004, 32'd10);
        wr(32'hF000_0004, 32'h5555_AAAA);
        rd_chk("cycle_clr", 32'hF000_0004, 32'd0);
        step(1);
        rd_chk("cycle_after_clr", 32'hF000_0004, 32'd1);
        force dut.cycle = 32'hFFFF_FFFF;
        #1;
        release dut.cycle;
        rd_chk("cycle_max", 32'hF000_0004, 32'hFFFF_FFFF);
        step(1);
        rd_chk("cycle_wrap", 32'hF000_0004, 32'h0);

        // Timer: CMP write edge moves CYCLE 0 -> 1
        wr(32'hF000_0008, 32'd20);
        rd_chk("cmp_rd", 32'hF000_0008, 32'd20);
        rd_chk("cycle_1", 32'hF000_0004, 32'd1);
        step(18);
        rd_chk("cycle_19", 32'hF000_0004, 32'd19);
        chk("irq_pre19", {31'h0, irq}, 32'h0);
        step(1);
        chk("irq_at20", {31'h0, irq}, 32'h0);
        step(1);
        chk("irq_set", {31'h0, irq}, 32'h1);
        rd_chk("status_set", 32'hF000_000C, 32'h1);
        wr(32'hF000_000C, 32'h1);
        chk("irq_w1c", {31'h0, irq}, 32'h0);
        rd_chk("status_clr", 32'hF000_000C, 32'h0);
        rd_chk("cycle_22", 32'hF000_0004, 32'd22);
        wr(32'hF000_0008, 32'd30);
        step(7);
        rd_chk("cycle_30", 32'hF000_0004, 32'd30);
        wr(32'hF000_000C, 32'h1);
        chk("irq_set_wins", {31'h0, irq}, 32'h1);
        wr(32'hF000_000C, 32'h1);
        chk("irq_w1c2", {31'h0, irq}, 32'h0);

        // RAM
        wr(32'h0000_0044, 32'hDEAD_BEEF);
        wr(32'h0000_0040, 32'h1234_5678);
        rd_chk("ram_40", 32'h0000_0040, 32'h1234_5678);
        rd_chk("ram_44", 32'h0000_0044, 32'hDEAD_BEEF);
        rd_chk("ram_byteoff", 32'h0000_0043, 32'h1234_5678);

        // LED
        wr(32'hF000_0000, 32'hABCD_5A5A);
        chk("led_out", {16'h0, led}, 32'h0000_5A5A);
        rd_chk("led_rd", 32'hF000_0000, 32'h0000_5A5A);

        // Unmapped space
        wr(32'h8000_0000, 32'hFFFF_FFFF);
        wr(32'h8000_0040, 32'hFFFF_FFFF);
        rd_chk("unmap_rd", 32'h8000_0000, 32'h0);
        rd_chk("unmap_ram", 32'h0000_0040, 32'h1234_5678);
        rd_chk("unmap_cmp", 32'hF000_0008, 32'd30);
        chk("unmap_led", {16'h0, led}, 32'h0000_5A5A);
        rd_chk("unimpl_off", 32'hF000_0020, 32'h0);

        // Reset wins over MMIO writes; RAM write still occurs
        rst = 1'b1;
        wr(32'hF000_0000, 32'h0000_FFFF);
        chk("rst_led_wr", {16'h0, led}, 32'h0);
        wr(32'h0000_0100, 32'hCAFE_F00D);
        rd_chk("rst_ram_wr", 32'h0000_0100, 32'hCAFE_F00D);
        rd_chk("rst_cycle2", 32'hF000_0004, 32'h0);
        rd_chk("rst_stores2", 32'hF000_0010, 32'h0);
        rst = 1'b0;

        // Store counter: 5 mixed stores
`ifdef DMEM_STORE_STATS_EN
        stores_exp = 32'd5;
`else
        stores_exp = 32'd0;
`endif
        wr(32'h0000_0080, 32'h1);
        wr(32'hF000_0000, 32'h3);
        wr(32'h9000_0000, 32'h7);
        wr(32'hF000_0008, 32'h0);
        wr(32'hF000_000C, 32'h0);
        rd_chk("stores_5", 32'hF000_0010, stores_exp);
        step(1);
        rd_chk("stores_rd_only", 32'hF000_0010, stores_exp);
        wr(32'hF000_0010, 32'h1);
        rd_chk("stores_clr", 32'hF000_0010, 32'h0);
        chk("led_3", {16'h0, led}, 32'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
